bounce_gen: RTL and testbench

BOUNCE_GEN -- requirements
Module: bounce_gen

---
 rtl/bounce_gen.sv | 116 +++++++++++
 tb/tb_bounce_gen.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bounce_gen.sv
// Mechanical push-button emulator: turns an ideal level on `clean` into a
// deterministic, LFSR-timed bouncy waveform on `noisy`, then holds it stable.
module bounce_gen #(
  parameter int unsigned BOUNCE_COUNT  = 4,
  parameter int unsigned DUR_LOG2      = 11,
  parameter int unsigned SETTLE_CYCLES = 700000,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic clk,
  input  logic reset,
  input  logic clean,
  output logic noisy,
  output logic busy,
  output logic done
);

  localparam logic [15:0] SEED_EFF    = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [23:0] SETTLE_LOAD = 24'(SETTLE_CYCLES);
  localparam logic [15:0] DUR_MASK    = 16'((32'd1 << DUR_LOG2) - 32'd1);
  localparam int          GW          = (BOUNCE_COUNT < 1) ? 1 : $clog2(BOUNCE_COUNT + 1);
  localparam logic [GW-1:0] BC_MAX    = GW'(BOUNCE_COUNT);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    GLITCH,
    SETTLE
  } state_e;

  state_e        state_q;
  logic          noisy_q;
  logic          busy_q;
  logic          done_q;
  logic          target_q;
  logic [23:0]   cnt_q;
  logic [GW-1:0] gcnt_q;
  logic [15:0]   lfsr_q;
  logic [15:0]   lfsr_d;
  logic [23:0]   durRand;
  logic          expired;

  // Fibonacci LFSR for x^16+x^14+x^13+x^11+1, free-running in every state.
  assign lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign durRand = {8'd0, lfsr_q & DUR_MASK} + 24'd1;
  assign expired = (cnt_q == 24'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      noisy_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      target_q <= 1'b0;
      cnt_q    <= '0;
      gcnt_q   <= '0;
      lfsr_q   <= SEED_EFF;
    end else begin
      lfsr_q <= lfsr_d;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clean != noisy_q) begin
            state_q  <= HOLD;
            target_q <= clean;
            noisy_q  <= clean;
            busy_q   <= 1'b1;
            cnt_q    <= durRand;
            gcnt_q   <= '0;
          end
        end
        HOLD: begin
          if (expired) begin
            if (gcnt_q != BC_MAX) begin
              state_q <= GLITCH;
              noisy_q <= ~target_q;
              cnt_q   <= durRand;
              gcnt_q  <= gcnt_q + 1'b1;
            end else begin
              state_q <= SETTLE;
              noisy_q <= target_q;
              cnt_q   <= SETTLE_LOAD;
            end
          end else begin
            cnt_q <= cnt_q - 24'd1;
          end
        end
        GLITCH: begin
          if (expired) begin
            state_q <= HOLD;
            noisy_q <= target_q;
            cnt_q   <= durRand;
          end else begin
            cnt_q <= cnt_q - 24'd1;
          end
        end
        SETTLE: begin
          // Completion lands in IDLE, so clean is re-examined on the done cycle.
          if (expired) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 24'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign noisy = noisy_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_bounce_gen.sv
// Bench for bounce_gen: predicts each burst's per-cycle noisy/busy/done trace
// from an LFSR reference and checks it against two instances (2 and 0 glitches).
module tb_bounce_gen;

  localparam int          BC   = 2;
  localparam int          DL   = 3;
  localparam int          SC   = 16;
  localparam logic [15:0] SEED = 16'hACE1;

  typedef struct packed {
    logic n;
    logic b;
    logic d;
  } exp_t;

  logic clk;
  logic reset;
  logic clean;
  logic clean0;
  logic noisy;
  logic busy;
  logic done;
  logic noisy0;
  logic busy0;
  logic done0;

  logic [15:0] tbLfsr;
  logic [15:0] vEnd;
  logic [15:0] vEnd2;
  int          dur0;

  exp_t q[$];
  exp_t q0[$];
  exp_t monE;
  exp_t monE0;

  int checks = 0;
  int errors = 0;

  bounce_gen #(
    .BOUNCE_COUNT (BC),
    .DUR_LOG2     (DL),
    .SETTLE_CYCLES(SC),
    .SEED         (SEED)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .clean(clean),
    .noisy(noisy),
    .busy (busy),
    .done (done)
  );

  bounce_gen #(
    .BOUNCE_COUNT (0),
    .DUR_LOG2     (DL),
    .SETTLE_CYCLES(SC),
    .SEED         (SEED)
  ) dut0 (
    .clk  (clk),
    .reset(reset),
    .clean(clean0),
    .noisy(noisy0),
    .busy (busy0),
    .done (done0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] lfsrStep(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [15:0] lfsrAdvance(input logic [15:0] v, input int n);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = lfsrStep(r);
    return r;
  endfunction

  // Reference LFSR: the value held here is what the next load edge will use.
  always @(posedge clk or negedge reset) begin
    if (!reset) tbLfsr <= SEED;
    else        tbLfsr <= lfsrStep(tbLfsr);
  end

  task automatic checkOutput(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic pushEntry(input bit which, input logic n, input logic b, input logic d);
    exp_t e;
    e.n = n;
    e.b = b;
    e.d = d;
    if (which) q0.push_back(e);
    else       q.push_back(e);
  endtask

  task automatic pushSegment(input bit which, input logic lvl, input int len, input logic b);
    for (int i = 0; i < len; i++) pushEntry(which, lvl, b, 1'b0);
  endtask

  task automatic pushBurst(input bit which, input int bc, input logic tgt,
                           input logic [15:0] vStart, output logic [15:0] vOut);
    logic [15:0] v;
    int          len;
    v   = vStart;
    len = int'(v[DL-1:0]) + 1;
    pushSegment(which, tgt, len, 1'b1);
    v = lfsrAdvance(v, len);
    for (int i = 0; i < bc; i++) begin
      len = int'(v[DL-1:0]) + 1;
      pushSegment(which, ~tgt, len, 1'b1);
      v   = lfsrAdvance(v, len);
      len = int'(v[DL-1:0]) + 1;
      pushSegment(which, tgt, len, 1'b1);
      v   = lfsrAdvance(v, len);
    end
    pushSegment(which, tgt, SC, 1'b1);
    pushEntry(which, tgt, 1'b0, 1'b1);
    vOut = lfsrAdvance(v, SC + 1);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic idleCycles(input bit which, input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      pushEntry(which, lvl, 1'b0, 1'b0);
      nextCycle();
    end
  endtask

  task automatic applyStimulus(input bit which, input logic lvl, output logic [15:0] vOut);
    if (which) clean0 = lvl;
    else       clean  = lvl;
    pushEntry(which, ~lvl, 1'b0, 1'b0);
    pushBurst(which, which ? 0 : BC, lvl, tbLfsr, vOut);
  endtask

  task automatic drain(input bit which);
    int n;
    n = 0;
    while (((which ? q0.size() : q.size()) > 0) && n < 400) begin
      nextCycle();
      n++;
    end
    checks++;
    assert ((which ? q0.size() : q.size()) == 0) else begin
      errors++;
      $error("[TB] FAIL drain remaining=%0d expected=0", which ? q0.size() : q.size());
    end
  endtask

  // Scoreboard consumer: one expected entry per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (q.size() > 0) begin
        monE = q.pop_front();
        checkOutput("noisy", noisy, monE.n);
        checkOutput("busy",  busy,  monE.b);
        checkOutput("done",  done,  monE.d);
      end
      if (q0.size() > 0) begin
        monE0 = q0.pop_front();
        checkOutput("noisy0", noisy0, monE0.n);
        checkOutput("busy0",  busy0,  monE0.b);
        checkOutput("done0",  done0,  monE0.d);
      end
    end
  end

  initial begin
    reset  = 1'b0;
    clean  = 1'b0;
    clean0 = 1'b0;
    nextCycle();
    $display("[TB] reset state");
    checkOutput("rst_noisy", noisy, 1'b0);
    checkOutput("rst_busy",  busy,  1'b0);
    checkOutput("rst_done",  done,  1'b0);
    checkOutput("rst_noisy0", noisy0, 1'b0);
    nextCycle();
    reset = 1'b1;
    idleCycles(0, 1'b0, 4);

    $display("[TB] rising burst with clean toggled mid-burst");
    applyStimulus(0, 1'b1, vEnd);
    repeat (3) nextCycle();
    clean = 1'b0;
    repeat (2) nextCycle();
    clean = 1'b1;
    drain(0);
    idleCycles(0, 1'b1, 3);

    $display("[TB] falling burst");
    applyStimulus(0, 1'b0, vEnd);
    drain(0);
    idleCycles(0, 1'b0, 2);

    $display("[TB] back-to-back bursts");
    applyStimulus(0, 1'b1, vEnd);
    repeat (2) nextCycle();
    clean = 1'b0;
    pushBurst(0, BC, 1'b0, vEnd, vEnd2);
    drain(0);
    idleCycles(0, 1'b0, 3);

    $display("[TB] reset abort during glitch");
    reset = 1'b0;
    q.delete();
    repeat (2) nextCycle();
    reset = 1'b1;
    idleCycles(0, 1'b0, 3);
    dur0 = int'(tbLfsr[DL-1:0]) + 1;
    applyStimulus(0, 1'b1, vEnd);
    repeat (1 + dur0) nextCycle();
    checkOutput("abort_in_glitch_noisy", noisy, 1'b0);
    checkOutput("abort_in_glitch_busy",  busy,  1'b1);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("async_rst_noisy", noisy, 1'b0);
    checkOutput("async_rst_busy",  busy,  1'b0);
    checkOutput("async_rst_done",  done,  1'b0);
    q.delete();
    clean = 1'b0;
    nextCycle();
    nextCycle();
    reset = 1'b1;
    idleCycles(0, 1'b0, 3);
    applyStimulus(0, 1'b1, vEnd);
    drain(0);
    idleCycles(0, 1'b1, 2);

    $display("[TB] zero-glitch instance");
    applyStimulus(1, 1'b1, vEnd);
    drain(1);
    idleCycles(1, 1'b1, 2);

    nextCycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
